mat_fifo_line_reader: RTL
=========================

# mat_fifo_line_reader

Read-side consumer of the matrix prefetch FIFO. It drains the FIFO's first-word-fall-through port (data/valid/pop-enable) and re-emits pixels as a framed ready/valid stream with sof/sol/eol/eof markers. It counts H_ACTIVE×V_ACTIVE pixels per frame, triggered by a start pulse. It sits entirely in the read clock domain between the FIFO and downstream image-processing stages.

## Interface
- DATA_WIDTH, 32: pixel word width; must equal the FIFO read data width.
- H_ACTIVE, 1280: pixels per line, legal 1–4095.
- V_ACTIVE, 720: lines per frame, legal 1–4095.
- rd_clk  in  1  read clock.
- rd_rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle frame start request.
- abort  in  1  synchronous frame abort; priority over start.
- fifo_rd_data  in  DATA_WIDTH  FIFO head word, valid when fifo_rd_vld=1.
- fifo_rd_vld  in  1  FIFO head valid.
- fifo_rd_en  out  1  pop request; a pop occurs when fifo_rd_vld & fifo_rd_en.
- m_data  out  DATA_WIDTH  output pixel.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_sof, m_sol, m_eol, m_eof  out  1 each  frame/line markers, qualified by m_valid.
- busy  out  1  frame in progress (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start & ~abort.
  - RUN→DRAIN on the pop of pixel (col=H_ACTIVE-1, row=V_ACTIVE-1).
  - DRAIN→IDLE when m_valid & m_ready.
  - Any state→IDLE on abort.
- fifo_rd_en = (state==RUN) & (~m_valid | m_ready). Combinational, no dependence on fifo_rd_vld.
- Output register:
  - On pop, load m_data plus markers and set m_valid.
  - Otherwise, if m_ready, clear m_valid.
  - m_data and markers hold while m_valid & ~m_ready.
- Counters:
  - col counts 0..H_ACTIVE-1; row counts 0..V_ACTIVE-1; width $clog2(max+1).
  - Both increment on pop only. col wraps to 0 and row increments on col=H_ACTIVE-1.
  - Both clear on entering RUN and on abort.
- Markers, computed from the counters at the pop:
  - sof = (col=0 & row=0).
  - sol = (col=0).
  - eol = (col=H_ACTIVE-1).
  - eof = eol & (row=V_ACTIVE-1).
  - With H_ACTIVE=1, sol and eol assert on every beat.
- start while busy is ignored. start in the same cycle as the DRAIN→IDLE transition is ignored.
- frame_done asserts in the cycle the eof beat handshakes (m_valid & m_ready & m_eof).
- abort:
  - fifo_rd_en goes low combinationally in the abort cycle.
  - m_valid and all markers clear on the next edge, discarding any held word.
  - frame_done is not pulsed.
  - FIFO contents are not flushed by this block.

## Timing
- Reset values: m_valid=0, m_data=0, all markers=0, busy=0, frame_done=0, state=IDLE, col=row=0. fifo_rd_en is therefore 0 out of reset.
- Latency:
  - start → first fifo_rd_en=1 is 1 cycle, since state registers RUN.
  - pop → m_valid is 1 cycle.
- Throughput: 1 pixel/cycle when fifo_rd_vld=1 and m_ready=1 continuously. Backpressure propagates to fifo_rd_en in the same cycle.
- Empty FIFO (fifo_rd_vld=0) with fifo_rd_en=1: no pop, counters hold, m_valid drops after the current word is accepted.
- busy stays high through DRAIN and falls the cycle after the eof handshake.

## Structure
- Shared package mat_fifo_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - a counter-width constant function;
  - the marker bundle typedef {sof, sol, eol, eof}.
- Single flat module. The output register is inline; no sub-module is warranted.
- Verification instantiates the real prefetch FIFO as the upstream source.

## Test plan
- **Nominal frame.** H_ACTIVE=4, V_ACTIVE=3, FIFO preloaded with 0..11, m_ready=1, start pulse. Required: m_data 0..11 on consecutive cycles. m_sof on 0; m_sol on 0, 4, 8; m_eol on 3, 7, 11; m_eof on 11. frame_done on the cycle beat 11 handshakes. busy low 1 cycle later.
- **Backpressure.** Same setup, m_ready toggling 1/0 each cycle. Required: every word appears exactly once, in order. m_data is stable while m_valid & ~m_ready. fifo_rd_en=0 whenever m_valid & ~m_ready.
- **Underflow.** Write 0..11 into the FIFO at one word per 3 cycles. Required: no duplicated or dropped words. m_valid gaps appear. Counters end at col=0, row=0 after eof.
- **Abort.** Abort after the 6th pop. Required: fifo_rd_en=0 the same cycle. m_valid=0 the next cycle. No frame_done. A next start yields m_sof on the next FIFO word.
- **Degenerate geometry.** H_ACTIVE=1, V_ACTIVE=1, start with one word 0xA5. Required: a single beat with sof, sol, eol and eof all high, then frame_done. A second start in the same cycle as that handshake is ignored.
- **Reset.** Assert rd_rst mid-frame with m_valid=1. Required: all outputs take their reset values immediately, asynchronously.

Source files
------------

// File: rtl/mat_fifo_pkg.sv
// Shared types for the matrix prefetch FIFO read side.
// Contents: reader state enum, counter-width helper, and the marker bundle
// that travels alongside each output pixel.
package mat_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    typedef struct packed {
        logic sof;
        logic sol;
        logic eol;
        logic eof;
    } marker_t;

endpackage

// File: rtl/mat_fifo_line_reader.sv
// Drains the prefetch FIFO's first-word-fall-through port and re-emits the
// pixels as a framed ready/valid stream (sof/sol/eol/eof) of H_ACTIVE x V_ACTIVE.
// Latency: pop -> m_valid one cycle; start -> first fifo_rd_en one cycle.
// Backpressure: fifo_rd_en drops in the same cycle the output word is held.
// Ports: rd_clk/rd_rst (async, active-high); start/abort frame control;
//        fifo_rd_* FWFT source; m_* framed output; busy, frame_done status.
module mat_fifo_line_reader
    import mat_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_vld,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_sol,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = cnt_width(H_ACTIVE);
    localparam int RW = cnt_width(V_ACTIVE);
    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

    rd_state_t             state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    marker_t               mk_q, mk_d;

    logic pop;
    logic out_hs;
    logic col_last;
    logic row_last;

    // Pull a word only when the output register is free or being emptied;
    // abort kills the pop in the same cycle so nothing new is consumed.
    assign fifo_rd_en = (state_q == ST_RUN) & (~m_valid_q | m_ready) & ~abort;
    assign pop        = fifo_rd_vld & fifo_rd_en;
    assign out_hs     = m_valid_q & m_ready;
    assign col_last   = (col_q == COL_LAST);
    assign row_last   = (row_q == ROW_LAST);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        mk_d      = mk_q;

        if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_rd_data;
            mk_d.sof  = (col_q == '0) & (row_q == '0);
            mk_d.sol  = (col_q == '0);
            mk_d.eol  = col_last;
            mk_d.eof  = col_last & row_last;
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (pop && col_last && row_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Any start seen here is dropped: next state is IDLE, not RUN.
                if (out_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort discards the held word; FIFO contents are left untouched.
        if (abort) begin
            state_d   = ST_IDLE;
            col_d     = '0;
            row_d     = '0;
            m_valid_d = 1'b0;
            mk_d      = '0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            mk_q      <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            mk_q      <= mk_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_sof      = mk_q.sof;
    assign m_sol      = mk_q.sol;
    assign m_eol      = mk_q.eol;
    assign m_eof      = mk_q.eof;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = out_hs & mk_q.eof & ~abort;

endmodule
